alu_mc: RTL and testbench

- Parametrised, registered successor of the single-cycle datapath ALU in the pipelined CPU.
- Keeps the existing 4-bit operation set: add, sub, and, or, xor, lui, sll, srl, sra, popcount.
- Adds iterative unsigned multiply/divide (MUL, MULHU, DIVU, REMU), a valid/ready handshake, a zero flag and a flush input.
- Sits in the EX stage; the hazard unit stalls on in_ready=0.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_muldiv_iter.sv | 101 ++++++++++
 rtl/alu_mc.sv | 141 ++++++++++++++
 tb/tb_alu_mc.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle EX-stage ALU.
// Holds the 5-bit operation codes and the sequencer state encoding.
// Legacy codes show bit 3 cleared wherever the hardware ignores it.
package alu_pkg;

    localparam logic [4:0] ALU_ADD   = 5'b00000;
    localparam logic [4:0] ALU_AND   = 5'b00001;
    localparam logic [4:0] ALU_XOR   = 5'b00010;
    localparam logic [4:0] ALU_SLL   = 5'b00011;
    localparam logic [4:0] ALU_SUB   = 5'b00100;
    localparam logic [4:0] ALU_OR    = 5'b00101;
    localparam logic [4:0] ALU_LUI   = 5'b00110;
    localparam logic [4:0] ALU_SRL   = 5'b00111;
    localparam logic [4:0] ALU_POPC  = 5'b01011;
    localparam logic [4:0] ALU_SRA   = 5'b01111;
    localparam logic [4:0] ALU_MUL   = 5'b10000;
    localparam logic [4:0] ALU_MULHU = 5'b10001;
    localparam logic [4:0] ALU_DIVU  = 5'b10010;
    localparam logic [4:0] ALU_REMU  = 5'b10011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply / restoring divide, one bit per clock.
// Ports:
//   clock, resetn  - clock, asynchronous active-low reset
//   abort          - synchronous cancel of the running operation
//   start          - launch: latch a/b/is_div/sel_hi
//   is_div, sel_hi - operation select (divide, upper/remainder half)
//   a, b           - operands
//   done           - high during the final iteration cycle
//   result         - value produced by the final iteration (valid with done)
// The hi/lo register pair is shared: {product high, product low} for a
// multiply, {partial remainder, quotient} for a divide.
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             abort,
    input  logic             start,
    input  logic             is_div,
    input  logic             sel_hi,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int SHW = $clog2(WIDTH);

    logic             busy_r;
    logic [SHW-1:0]   cnt_r;
    logic             div_r;
    logic             hi_sel_r;
    logic [WIDTH-1:0] op_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] hi_n_s;
    logic [WIDTH-1:0] lo_n_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH:0]   diff_s;

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        sum_s    = {1'b0, hi_r} + (lo_r[0] ? {1'b0, op_r} : {(WIDTH+1){1'b0}});
        rem_sh_s = {hi_r, lo_r[WIDTH-1]};
        diff_s   = rem_sh_s - {1'b0, op_r};
        if (div_r) begin
            // A zero divisor never borrows: quotient fills with ones and the
            // remainder ends up holding the dividend.
            if (!diff_s[WIDTH]) begin
                hi_n_s = diff_s[WIDTH-1:0];
                lo_n_s = {lo_r[WIDTH-2:0], 1'b1};
            end else begin
                hi_n_s = rem_sh_s[WIDTH-1:0];
                lo_n_s = {lo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_n_s = sum_s[WIDTH:1];
            lo_n_s = {sum_s[0], lo_r[WIDTH-1:1]};
        end
    end

    assign done   = busy_r && (cnt_r == SHW'(WIDTH-1));
    assign result = hi_sel_r ? hi_n_s : lo_n_s;

    // Operand latch, iteration registers and bit counter.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            busy_r   <= 1'b0;
            cnt_r    <= {SHW{1'b0}};
            div_r    <= 1'b0;
            hi_sel_r <= 1'b0;
            op_r     <= {WIDTH{1'b0}};
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
        end else if (abort) begin
            busy_r <= 1'b0;
            cnt_r  <= {SHW{1'b0}};
        end else if (start) begin
            busy_r   <= 1'b1;
            cnt_r    <= {SHW{1'b0}};
            div_r    <= is_div;
            hi_sel_r <= sel_hi;
            op_r     <= is_div ? b : a;
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= is_div ? a : b;
        end else if (busy_r) begin
            hi_r  <= hi_n_s;
            lo_r  <= lo_n_s;
            cnt_r <= cnt_r + {{(SHW-1){1'b0}}, 1'b1};
            if (cnt_r == SHW'(WIDTH-1)) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= 1'b1;
            end
        end else begin
            busy_r <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Registered EX-stage ALU with single-cycle legacy ops and iterative
// unsigned MUL/MULHU/DIVU/REMU behind a valid/ready handshake.
// Ports:
//   clock, resetn       - clock, asynchronous active-low reset
//   flush               - synchronous abort of any in-flight op
//   in_valid / in_ready - operand handshake (in_ready = sequencer idle)
//   aluc                - op code (bit4=1 selects multiply/divide)
//   a, b                - operands; shift amount is a[SHW-1:0]
//   s, z                - registered result and zero flag
//   out_valid           - one-cycle pulse when s/z are freshly written
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int MD_EN = 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       aluc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             z,
    output logic             out_valid
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state_r;
    logic [WIDTH-1:0] s_r;
    logic             z_r;
    logic             out_valid_r;
    logic [4:0]       key_s;
    logic [SHW-1:0]   sh_s;
    logic [WIDTH-1:0] legacy_s;
    logic             md_op_s;
    logic             accept_s;
    logic             start_s;
    logic             md_done_s;
    logic [WIDTH-1:0] md_res_s;

    function automatic logic [WIDTH-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] c;
        c = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            c = c + {{(WIDTH-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Bit 3 only distinguishes the shift/popcount group (low bits 11);
    // elsewhere it is folded to 0 so one table entry covers both encodings.
    assign key_s = (aluc[1:0] == 2'b11) ? aluc : {aluc[4], 1'b0, aluc[2:0]};
    assign sh_s  = a[SHW-1:0];

    // Single-cycle result; unused and unsupported codes produce 0.
    always_comb begin
        case (key_s)
            ALU_ADD:  legacy_s = a + b;
            ALU_SUB:  legacy_s = a - b;
            ALU_AND:  legacy_s = a & b;
            ALU_OR:   legacy_s = a | b;
            ALU_XOR:  legacy_s = a ^ b;
            ALU_LUI:  legacy_s = b << (WIDTH/2);
            ALU_SLL:  legacy_s = b << sh_s;
            ALU_SRL:  legacy_s = b >> sh_s;
            ALU_SRA:  legacy_s = $signed(b) >>> sh_s;
            ALU_POPC: legacy_s = popcount(b);
            default:  legacy_s = {WIDTH{1'b0}};
        endcase
    end

    // Only 100xx launch the iterator; 101xx/11xxx complete in one cycle as 0.
    assign md_op_s  = (MD_EN != 0) && (aluc[4:2] == 3'b100);
    assign in_ready = (state_r == IDLE);
    assign accept_s = in_valid && in_ready && !flush;
    assign start_s  = accept_s && md_op_s;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_md (
        .clock  (clock),
        .resetn (resetn),
        .abort  (flush),
        .start  (start_s),
        .is_div (aluc[1]),
        .sel_hi (aluc[0]),
        .a      (a),
        .b      (b),
        .done   (md_done_s),
        .result (md_res_s)
    );

    // Sequencer and output register; flush beats accept and completion.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r     <= IDLE;
            s_r         <= {WIDTH{1'b0}};
            z_r         <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (flush) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && md_op_s) begin
                        state_r     <= aluc[1] ? DIV : MUL;
                        out_valid_r <= 1'b0;
                    end else if (in_valid) begin
                        s_r         <= legacy_s;
                        z_r         <= (legacy_s == {WIDTH{1'b0}});
                        out_valid_r <= 1'b1;
                    end else begin
                        out_valid_r <= 1'b0;
                    end
                end
                MUL, DIV: begin
                    if (md_done_s) begin
                        s_r         <= md_res_s;
                        z_r         <= (md_res_s == {WIDTH{1'b0}});
                        out_valid_r <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign s         = s_r;
    assign z         = z_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: a 32-bit instance for the full op set and
// multi-cycle corner cases, and a 16-bit instance for the width rerun.
module tb_alu_mc;
    import alu_pkg::*;

    logic        clock = 1'b0;
    logic        resetn;
    logic        flush;
    logic        in_valid32;
    logic        in_valid16;
    logic [4:0]  aluc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s32;
    logic        z32, ov32, rdy32;
    logic [15:0] s16;
    logic        z16, ov16, rdy16;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  aluc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_s;
    } vec_t;

    vec_t vecs[15];

    alu_mc #(.WIDTH(32), .MD_EN(1)) dut32 (
        .clock(clock), .resetn(resetn), .flush(flush),
        .in_valid(in_valid32), .in_ready(rdy32), .aluc(aluc),
        .a(a), .b(b), .s(s32), .z(z32), .out_valid(ov32)
    );

    alu_mc #(.WIDTH(16), .MD_EN(1)) dut16 (
        .clock(clock), .resetn(resetn), .flush(flush),
        .in_valid(in_valid16), .in_ready(rdy16), .aluc(aluc),
        .a(a[15:0]), .b(b[15:0]), .s(s16), .z(z16), .out_valid(ov16)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Launch one MD op and check latency, busy window, result and pulse width.
    task automatic md_run(input bit w16, input string name, input logic [4:0] op,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp);
        int lat;
        bit busy_bad;
        int width;
        width = w16 ? 16 : 32;
        aluc = op; a = av; b = bv;
        if (w16) in_valid16 = 1'b1; else in_valid32 = 1'b1;
        tick();
        in_valid16 = 1'b0; in_valid32 = 1'b0;
        lat = 0; busy_bad = 1'b0;
        while (!(w16 ? ov16 : ov32) && lat < 100) begin
            if (w16 ? rdy16 : rdy32) busy_bad = 1'b1;
            tick();
            lat++;
        end
        chk({name, " latency"}, lat, width);
        chk({name, " ready while busy"}, {31'd0, busy_bad}, 32'd0);
        chk({name, " s"}, w16 ? {16'h0, s16} : s32, exp);
        chk({name, " z"}, {31'd0, w16 ? z16 : z32}, {31'd0, exp == 32'd0});
        chk({name, " ready at done"}, {31'd0, w16 ? rdy16 : rdy32}, 32'd1);
        tick();
        chk({name, " pulse width"}, {31'd0, w16 ? ov16 : ov32}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        vecs[0]  = '{ALU_ADD,   32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        vecs[1]  = '{ALU_SRA,   32'h00000004, 32'h80000000, 32'hF8000000};
        vecs[2]  = '{ALU_LUI,   32'h0000DEAD, 32'h00001234, 32'h12340000};
        vecs[3]  = '{ALU_POPC,  32'h00000000, 32'hF0F00001, 32'h00000009};
        vecs[4]  = '{ALU_SUB,   32'h00000005, 32'h00000007, 32'hFFFFFFFE};
        vecs[5]  = '{5'b01001,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000};
        vecs[6]  = '{ALU_OR,    32'h0000F0F0, 32'h00000F00, 32'h0000FFF0};
        vecs[7]  = '{5'b01010,  32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0};
        vecs[8]  = '{ALU_SLL,   32'h0000001F, 32'h00000001, 32'h80000000};
        vecs[9]  = '{ALU_SRL,   32'h0000001F, 32'h80000000, 32'h00000001};
        vecs[10] = '{ALU_SRA,   32'h00000024, 32'h40000000, 32'h04000000};
        vecs[11] = '{5'b01110,  32'h00000000, 32'hABCD5678, 32'h56780000};
        vecs[12] = '{5'b10100,  32'h00000001, 32'h00000001, 32'h00000000};
        vecs[13] = '{5'b01000,  32'h00000007, 32'h00000008, 32'h0000000F};
        vecs[14] = '{5'b01100,  32'h00000000, 32'h00000001, 32'hFFFFFFFF};

        resetn = 1'b1; flush = 1'b0; in_valid32 = 1'b0; in_valid16 = 1'b0;
        aluc = 5'd0; a = 32'd0; b = 32'd0;
        #1 resetn = 1'b0;
        #20;
        chk("reset s", s32, 32'd0);
        chk("reset z", {31'd0, z32}, 32'd0);
        chk("reset out_valid", {31'd0, ov32}, 32'd0);
        resetn = 1'b1;
        tick();
        chk("ready after reset", {31'd0, rdy32}, 32'd1);
        chk("ready16 after reset", {31'd0, rdy16}, 32'd1);

        // Legacy ops, one accept per cycle.
        for (int i = 0; i < 15; i++) begin
            aluc = vecs[i].aluc; a = vecs[i].a; b = vecs[i].b;
            in_valid32 = 1'b1;
            tick();
            chk($sformatf("vec%0d out_valid", i), {31'd0, ov32}, 32'd1);
            chk($sformatf("vec%0d s", i), s32, vecs[i].exp_s);
            chk($sformatf("vec%0d z", i), {31'd0, z32}, {31'd0, vecs[i].exp_s == 32'd0});
            chk($sformatf("vec%0d ready", i), {31'd0, rdy32}, 32'd1);
        end
        in_valid32 = 1'b0;
        tick();
        chk("legacy out_valid drop", {31'd0, ov32}, 32'd0);

        md_run(1'b0, "mul",      ALU_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
        md_run(1'b0, "mulhu",    ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        md_run(1'b0, "mul2",     ALU_MUL,   32'h12345678, 32'h00000100, 32'h34567800);
        md_run(1'b0, "mulhu2",   ALU_MULHU, 32'h12345678, 32'h00000100, 32'h00000012);
        md_run(1'b0, "divu",     ALU_DIVU,  32'd100,      32'd7,        32'd14);
        md_run(1'b0, "remu",     ALU_REMU,  32'd100,      32'd7,        32'd2);
        md_run(1'b0, "divu0",    ALU_DIVU,  32'h00000055, 32'h00000000, 32'hFFFFFFFF);
        md_run(1'b0, "remu0",    ALU_REMU,  32'h00000055, 32'h00000000, 32'h00000055);

        // Back-to-back: next op held by upstream during DIVU, accepted on done.
        begin
            int lat;
            aluc = ALU_DIVU; a = 32'd100; b = 32'd7; in_valid32 = 1'b1;
            tick();
            aluc = ALU_ADD; a = 32'd4; b = 32'd6;
            lat = 0;
            while (!ov32 && lat < 100) begin
                tick();
                lat++;
            end
            chk("b2b div latency", lat, 32'd32);
            chk("b2b div s", s32, 32'd14);
            tick();
            in_valid32 = 1'b0;
            chk("b2b add out_valid", {31'd0, ov32}, 32'd1);
            chk("b2b add s", s32, 32'd10);
            tick();
            chk("b2b drop", {31'd0, ov32}, 32'd0);
        end

        // Flush on the 10th iteration edge of a MUL.
        aluc = ALU_MUL; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; in_valid32 = 1'b1;
        tick();
        in_valid32 = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush ready", {31'd0, rdy32}, 32'd1);
        chk("flush out_valid", {31'd0, ov32}, 32'd0);
        chk("flush s kept", s32, 32'd10);
        seen = 0;
        repeat (40) begin
            tick();
            if (ov32) seen++;
        end
        chk("flush no result", seen, 32'd0);
        aluc = ALU_ADD; a = 32'd2; b = 32'd3; in_valid32 = 1'b1;
        tick();
        in_valid32 = 1'b0;
        chk("post-flush add valid", {31'd0, ov32}, 32'd1);
        chk("post-flush add s", s32, 32'd5);

        // Flush wins over a simultaneous accept.
        aluc = ALU_SUB; a = 32'd9; b = 32'd1; in_valid32 = 1'b1; flush = 1'b1;
        tick();
        in_valid32 = 1'b0; flush = 1'b0;
        chk("flush+accept out_valid", {31'd0, ov32}, 32'd0);
        chk("flush+accept s", s32, 32'd5);

        // Async reset in the middle of a DIVU.
        aluc = ALU_DIVU; a = 32'd100; b = 32'd7; in_valid32 = 1'b1;
        tick();
        in_valid32 = 1'b0;
        repeat (5) tick();
        #2 resetn = 1'b0;
        #1;
        chk("async rst s", s32, 32'd0);
        chk("async rst out_valid", {31'd0, ov32}, 32'd0);
        chk("async rst ready", {31'd0, rdy32}, 32'd1);
        #1 resetn = 1'b1;
        tick();
        chk("ready after async rst", {31'd0, rdy32}, 32'd1);
        seen = 0;
        repeat (40) begin
            tick();
            if (ov32) seen++;
        end
        chk("async rst no result", seen, 32'd0);

        // 16-bit instance.
        aluc = ALU_ADD; a = 32'h0000FFFF; b = 32'h00000001; in_valid16 = 1'b1;
        tick();
        in_valid16 = 1'b0;
        chk("add16 valid", {31'd0, ov16}, 32'd1);
        chk("add16 s", {16'h0, s16}, 32'd0);
        chk("add16 z", {31'd0, z16}, 32'd1);
        md_run(1'b1, "mul16",   ALU_MUL,   32'h0000FFFF, 32'h0000FFFF, 32'h00000001);
        md_run(1'b1, "mulhu16", ALU_MULHU, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFE);
        md_run(1'b1, "divu16",  ALU_DIVU,  32'd100,      32'd7,        32'd14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
